onchip_memory_arbiter: RTL and testbench

Two-master round-robin arbiter with a built-in fill engine, placed in front of the 4096 x 32 single-port on-chip video memory. It lets the processor-side master and the video-DMA-side master share the one RAM port. It returns read data to the issuing master with fixed latency. On command, it sequences a block fill of a word range, for example clearing an overlay buffer, while holding both masters off.

---
 rtl/onchip_memory_arbiter_pkg.sv | 23 ++
 rtl/onchip_memory_fill_engine.sv | 78 +++++++
 rtl/onchip_memory_arbiter.sv | 142 ++++++++++++++
 tb/tb_onchip_memory_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_memory_arbiter_pkg.sv
// Shared types and defaults for the on-chip video memory arbiter and its fill engine.
package onchip_memory_arbiter_pkg;

    localparam int unsigned DefaultAddrW = 12;
    localparam int unsigned DefaultDataW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fill_state_e;

    typedef enum logic {
        MstM0,
        MstM1
    } master_id_e;

    typedef struct packed {
        logic       valid;
        master_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/onchip_memory_fill_engine.sv
// Block-fill sequencer: writes one latched pattern word per cycle over a wrapping address range.
module onchip_memory_fill_engine
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_count,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] fill_address,
    output logic [DATA_W-1:0] fill_writedata
);

    fill_state_e       state_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fill_start) begin
                        addr_q      <= fill_base;
                        remaining_q <= fill_count;
                        data_q      <= fill_data;
                        // An empty fill still reports completion, just without any writes.
                        if (fill_count != '0) begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    addr_q      <= addr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - (ADDR_W + 1)'(1);
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fill_busy      = busy_q;
    assign fill_done      = done_q;
    assign fill_address   = addr_q;
    assign fill_writedata = data_q;

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of the single-port video RAM, with fill engine override.
module onchip_memory_arbiter
    import onchip_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefaultAddrW,
    parameter int unsigned DATA_W       = DefaultDataW,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    input  logic                fill_start,
    input  logic [ADDR_W-1:0]   fill_base,
    input  logic [ADDR_W:0]     fill_count,
    input  logic [DATA_W-1:0]   fill_data,
    output logic                fill_busy,
    output logic                fill_done,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic [ADDR_W-1:0] fill_address;
    logic [DATA_W-1:0] fill_writedata;

    onchip_memory_fill_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill_engine (
        .clk            (clk),
        .reset          (reset),
        .fill_start     (fill_start),
        .fill_base      (fill_base),
        .fill_count     (fill_count),
        .fill_data      (fill_data),
        .fill_busy      (fill_busy),
        .fill_done      (fill_done),
        .fill_address   (fill_address),
        .fill_writedata (fill_writedata)
    );

    master_id_e last_q;
    rd_tag_t    pipe_q [READ_LATENCY];
    rd_tag_t    rd_new;

    logic req0;
    logic req1;
    logic arb_en;
    logic prefer_m0;
    logic grant0;
    logic grant1;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign arb_en    = ~reset & ~fill_busy;
    assign prefer_m0 = (last_q == MstM1);
    assign grant0    = arb_en & req0 & (~req1 | prefer_m0);
    assign grant1    = arb_en & req1 & (~req0 | ~prefer_m0);

    assign m0_waitrequest = ~grant0;
    assign m1_waitrequest = ~grant1;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (fill_busy && !reset) begin
            mem_address    = fill_address;
            mem_byteenable = '1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_writedata  = fill_writedata;
        end else if (grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_write ? m0_byteenable : '1;
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
            mem_writedata  = m0_writedata;
        end else if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_write ? m1_byteenable : '1;
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
            mem_writedata  = m1_writedata;
        end
    end

    // Read with write asserted is treated as a write only, so it must not enter the return pipe.
    always_comb begin
        rd_new.valid = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
        rd_new.id    = grant1 ? MstM1 : MstM0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= MstM1;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            if (grant0) begin
                last_q <= MstM0;
            end else if (grant1) begin
                last_q <= MstM1;
            end
            pipe_q[0] <= rd_new;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = pipe_q[READ_LATENCY-1].valid && (pipe_q[READ_LATENCY-1].id == MstM0);
    assign m1_readdatavalid = pipe_q[READ_LATENCY-1].valid && (pipe_q[READ_LATENCY-1].id == MstM1);

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed self-checking bench for onchip_memory_arbiter with a behavioural 4096x32 RAM.
module tb_onchip_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m1_read, m0_write, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        fill_start;
    logic [11:0] fill_base;
    logic [12:0] fill_count;
    logic [31:0] fill_data;
    logic        fill_busy, fill_done;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic [31:0] ram [4096];
    logic [31:0] rd_q = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    onchip_memory_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .fill_start       (fill_start),
        .fill_base        (fill_base),
        .fill_count       (fill_count),
        .fill_data        (fill_data),
        .fill_busy        (fill_busy),
        .fill_done        (fill_done),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata)
    );

    // Synchronous-address RAM: read data appears the cycle after the accepted read.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                rd_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_address = '0; m0_byteenable = 4'hF; m0_read = 0; m0_write = 0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = 4'hF; m1_read = 0; m1_write = 0; m1_writedata = '0;
        fill_start = 0; fill_base = '0; fill_count = '0; fill_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] exp_a;
        int          nw;
        int          cyc;
        int          bad;

        idle();
        reset = 1;
        m0_read = 1;
        m1_write = 1;
        tick(); #1;
        chk("rst_wait0", m0_waitrequest, 1);
        chk("rst_wait1", m1_waitrequest, 1);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_wr", mem_write, 0);
        tick(); #1;
        chk("rst_busy", fill_busy, 0);
        chk("rst_done", fill_done, 0);
        chk("rst_rdv0", m0_readdatavalid, 0);
        chk("rst_rdv1", m1_readdatavalid, 0);
        idle();
        reset = 0;

        // Contention: tie-break starts with m0, then alternates.
        for (int i = 0; i < 4; i++) begin
            tick();
            m0_write = 1; m0_address = 12'h000; m0_writedata = 32'h100 + 32'((i + 1) / 2);
            m1_write = 1; m1_address = 12'h001; m1_writedata = 32'h200 + 32'(i / 2);
            #1;
            chk("cont_wait0", m0_waitrequest, 32'(i % 2));
            chk("cont_wait1", m1_waitrequest, 32'((i + 1) % 2));
            chk("cont_addr", mem_address, 32'(i % 2));
        end
        tick(); idle(); #1;
        chk("cont_ram0", ram[0], 32'h101);
        chk("cont_ram1", ram[1], 32'h201);

        tick(); idle(); m0_write = 1; m0_address = 12'h010; m0_writedata = 32'hDEADBEEF;
        tick(); idle(); m0_write = 1; m0_address = 12'h020; m0_writedata = 32'hFFFFFFFF;

        // Single read with byteenable forced to all lanes.
        tick(); idle(); m0_read = 1; m0_address = 12'h010; m0_byteenable = 4'h3; #1;
        chk("rd_wait0", m0_waitrequest, 0);
        chk("rd_cs", mem_chipselect, 1);
        chk("rd_wr", mem_write, 0);
        chk("rd_be", mem_byteenable, 4'hF);
        chk("rd_addr", mem_address, 12'h010);
        tick(); idle(); #1;
        chk("rd_rdv0", m0_readdatavalid, 1);
        chk("rd_data0", m0_readdata, 32'hDEADBEEF);
        chk("rd_rdv1", m1_readdatavalid, 0);
        tick(); #1;
        chk("rd_rdv0_off", m0_readdatavalid, 0);

        // Byte-lane merge.
        tick(); m1_write = 1; m1_address = 12'h020; m1_writedata = 32'h11223344;
        m1_byteenable = 4'b0101; #1;
        chk("be_wait1", m1_waitrequest, 0);
        chk("be_be", mem_byteenable, 4'b0101);
        tick(); idle(); m1_read = 1; m1_address = 12'h020; #1;
        chk("be_rdwait1", m1_waitrequest, 0);
        tick(); idle(); #1;
        chk("be_rdv1", m1_readdatavalid, 1);
        chk("be_data1", m1_readdata, 32'hFF22FF44);
        chk("be_rdv0", m0_readdatavalid, 0);

        // Read and write together: write wins, no data returned.
        tick(); idle(); m0_read = 1; m0_write = 1; m0_address = 12'h030; m0_writedata = 32'h55;
        #1;
        chk("rw_wr", mem_write, 1);
        tick(); idle(); #1;
        chk("rw_rdv0", m0_readdatavalid, 0);
        chk("rw_ram", ram[12'h030], 32'h55);

        // Wrapping fill with a read accepted in the launch cycle.
        tick(); idle();
        fill_start = 1; fill_base = 12'hFFE; fill_count = 13'd4; fill_data = 32'hA5A5A5A5;
        m0_read = 1; m0_address = 12'h010; #1;
        chk("fw_wait0_launch", m0_waitrequest, 0);
        chk("fw_busy_launch", fill_busy, 0);
        tick(); fill_start = 0; #1;
        chk("fw_busy", fill_busy, 1);
        chk("fw_wait0", m0_waitrequest, 1);
        chk("fw_wr", mem_write, 1);
        chk("fw_addr", mem_address, 12'hFFE);
        chk("fw_rdv0", m0_readdatavalid, 1);
        chk("fw_data0", m0_readdata, 32'hDEADBEEF);
        for (int k = 1; k < 4; k++) begin
            tick(); #1;
            exp_a = 12'hFFE + 12'(k);
            chk("fw_busy_k", fill_busy, 1);
            chk("fw_wait0_k", m0_waitrequest, 1);
            chk("fw_addr_k", mem_address, exp_a);
        end
        tick(); #1;
        chk("fw_done", fill_done, 1);
        chk("fw_busy_end", fill_busy, 0);
        chk("fw_wait0_end", m0_waitrequest, 0);
        tick(); idle(); #1;
        chk("fw_done_off", fill_done, 0);
        chk("fw_ram_ffe", ram[12'hFFE], 32'hA5A5A5A5);
        chk("fw_ram_fff", ram[12'hFFF], 32'hA5A5A5A5);
        chk("fw_ram_000", ram[12'h000], 32'hA5A5A5A5);
        chk("fw_ram_001", ram[12'h001], 32'hA5A5A5A5);

        // Zero-length fill.
        tick(); fill_start = 1; fill_count = 13'd0; #1;
        tick(); fill_start = 0; #1;
        chk("f0_done", fill_done, 1);
        chk("f0_busy", fill_busy, 0);
        chk("f0_wr", mem_write, 0);
        tick(); #1;
        chk("f0_done_off", fill_done, 0);

        // Full-memory fill.
        tick(); fill_start = 1; fill_base = 12'h123; fill_count = 13'd4096;
        fill_data = 32'h5A5A0000; #1;
        tick(); fill_start = 0; #1;
        nw = 0;
        cyc = 0;
        while (!fill_done && cyc < 5000) begin
            if (mem_write) nw++;
            tick(); #1;
            cyc++;
        end
        chk("ff_done_seen", fill_done, 1);
        chk("ff_writes", nw, 4096);
        bad = 0;
        for (int a = 0; a < 4096; a++) begin
            if (ram[a] !== 32'h5A5A0000) bad++;
        end
        chk("ff_ram_bad", bad, 0);
        tick(); idle(); #1;

        // Reset in the middle of a fill.
        tick(); fill_start = 1; fill_base = 12'h000; fill_count = 13'd100; fill_data = 32'h1; #1;
        tick(); fill_start = 0;
        tick();
        tick(); #1;
        chk("fr_busy", fill_busy, 1);
        tick(); reset = 1; m0_read = 1; #1;
        chk("fr_wait0", m0_waitrequest, 1);
        chk("fr_cs", mem_chipselect, 0);
        tick(); reset = 0; m0_read = 0; #1;
        chk("fr_busy_off", fill_busy, 0);
        chk("fr_done", fill_done, 0);
        chk("fr_cs_off", mem_chipselect, 0);
        tick(); #1;
        chk("fr_done_later", fill_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
